// File: rtl/seq_bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer that feeds the 1101 detector.
// Holds the FSM state type, the load-length width and the frame-length clamp.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int lw_of(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int WIDTH_DEFAULT = 8;
  localparam int LW_DEFAULT    = lw_of(WIDTH_DEFAULT);

  // A zero or oversized request means "send the whole word".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Word-load handshake, bit-advance strobe and serial output of the serializer.
// The master side is the word source; the slave side is the serializer itself.
interface seq_bit_serializer_if
  import seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int LW    = lw_of(WIDTH)
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LW-1:0]    load_len;
  logic             en;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, load_len, en,
    input  load_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, load_len, en,
    output load_ready, ser_out, ser_valid, busy, done
  );

endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: accepts variable-length words and shifts them out
// one bit per enabled clock, handing off gaplessly on the last bit of a frame.
//
// state | meaning
// IDLE  | no frame; ser_out=0, ser_valid=0, ready for a word
// SHIFT | frame active; ser_out carries the current bit
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MSB_FIRST = 1
) (
  input logic                clk,
  input logic                rst,
  seq_bit_serializer_if.slave bus
);

  localparam int LW = lw_of(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_load;
  logic [WIDTH-1:0] data_masked;
  logic [LW-1:0]    cnt;
  logic [LW-1:0]    len_eff;
  logic             last_bit;
  logic             ready;
  logic             accept;
  logic             done_q;
  logic             cur_bit;

  always_comb begin
    state_nx    = state;
    len_eff     = LW'(eff_len(32'(bus.load_len), WIDTH));
    last_bit    = (state == SHIFT) && (cnt == LW'(1)) && bus.en;
    ready       = (state == IDLE) || last_bit;
    accept      = bus.load_valid && ready;
    // Drop bits above the frame so they can never reach ser_out.
    data_masked = bus.load_data & ~({WIDTH{1'b1}} << len_eff);
    sreg_load   = data_masked;
    if (MSB_FIRST != 0) begin
      sreg_load = data_masked << (WIDTH - int'(len_eff));
    end
    if (accept) begin
      state_nx = SHIFT;
    end else if (last_bit) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= last_bit && !accept;
      if (accept) begin
        sreg <= sreg_load;
        cnt  <= len_eff;
      end else if (state == SHIFT && bus.en) begin
        cnt  <= cnt - LW'(1);
        sreg <= (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
      end
    end
  end

  assign cur_bit       = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
  assign bus.load_ready = ready;
  assign bus.ser_valid  = (state == SHIFT);
  assign bus.busy       = (state == SHIFT);
  assign bus.ser_out    = (state == SHIFT) && cur_bit;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Randomised scoreboard bench: an MSB-first and an LSB-first serializer share one
// word source; expected bit streams are queued on accept and popped per enabled clock.
`timescale 1ns/1ps
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic [3:0] load_len;
  logic       en;
  int         en_div;
  int         cyc;

  int checks = 0;
  int errors = 0;

  bit q_m[$];
  bit q_l[$];
  bit exp_done;
  bit model_on;

  seq_bit_serializer_if #(.WIDTH(8)) ifm ();
  seq_bit_serializer_if #(.WIDTH(8)) ifl ();

  assign ifm.load_valid = load_valid;
  assign ifm.load_data  = load_data;
  assign ifm.load_len   = load_len;
  assign ifm.en         = en;
  assign ifl.load_valid = load_valid;
  assign ifl.load_data  = load_data;
  assign ifl.load_len   = load_len;
  assign ifl.en         = en;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(ifm.slave));
  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(ifl.slave));

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a word of L bits becomes L queued bits in transmit order.
  function automatic void push_word(input logic [7:0] d, input logic [3:0] len);
    int l;
    l = (len == 0 || len > 8) ? 8 : int'(len);
    for (int i = l - 1; i >= 0; i--) q_m.push_back(d[i]);
    for (int i = 0; i < l; i++) q_l.push_back(d[i]);
  endfunction

  // en pacing: en_div=N raises en every Nth clock, en_div=0 is random.
  initial begin
    en  = 1'b0;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (en_div == 0) en = 1'($urandom_range(0, 1));
      else             en = ((cyc % en_div) == 0);
    end
  end

  // Monitor / scoreboard: compare what the DUTs present, then advance the model.
  initial begin
    bit exp_ready, last, acc;
    forever begin
      @(negedge clk);
      if (model_on && !rst) begin
        exp_ready = (q_m.size() == 0) || (q_m.size() == 1 && en);
        chk("ready_m", 32'(ifm.load_ready), 32'(exp_ready));
        chk("ready_l", 32'(ifl.load_ready), 32'(exp_ready));
        chk("valid_m", 32'(ifm.ser_valid), 32'(q_m.size() != 0));
        chk("valid_l", 32'(ifl.ser_valid), 32'(q_l.size() != 0));
        chk("busy_m", 32'(ifm.busy), 32'(q_m.size() != 0));
        chk("ser_m", 32'(ifm.ser_out), 32'(q_m.size() != 0 ? q_m[0] : 1'b0));
        chk("ser_l", 32'(ifl.ser_out), 32'(q_l.size() != 0 ? q_l[0] : 1'b0));
        chk("done_m", 32'(ifm.done), 32'(exp_done));
        chk("done_l", 32'(ifl.done), 32'(exp_done));
        last = (q_m.size() == 1) && en;
        if (en && q_m.size() != 0) begin
          void'(q_m.pop_front());
          void'(q_l.pop_front());
        end
        acc = load_valid && exp_ready;
        if (acc) push_word(load_data, load_len);
        exp_done = last && !acc;
      end
    end
  end

  // Offer a word at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [3:0] len);
    bit acc;
    load_valid = 1'b1;
    load_data  = d;
    load_len   = len;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      acc = load_valid && ifm.load_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk("send_timeout", 32'd1, 32'd0);
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 400 && !idle; k++) begin
      @(negedge clk);
      idle = !ifm.ser_valid && (q_m.size() == 0) && !exp_done;
    end
    if (!idle) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks without any clock edge.
  task automatic apply_reset();
    #2;
    rst        = 1'b1;
    load_valid = 1'b0;
    #1;
    chk("rst_ser_m", 32'(ifm.ser_out), 32'd0);
    chk("rst_ser_l", 32'(ifl.ser_out), 32'd0);
    chk("rst_valid", 32'(ifm.ser_valid), 32'd0);
    chk("rst_done", 32'(ifm.done), 32'd0);
    q_m.delete();
    q_l.delete();
    exp_done = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ifm.load_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    en_div     = 1;
    model_on   = 1'b0;
    exp_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_on = 1'b1;
    apply_reset();

    send(8'h0D, 4'd4);
    load_valid = 1'b0;
    wait_idle();

    send(8'h0D, 4'd4);
    send(8'h0B, 4'd4);
    load_valid = 1'b0;
    wait_idle();

    en_div = 3;
    send(8'hA5, 4'd8);
    load_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_data  = 8'h33;
    load_len   = 4'd8;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    wait_idle();

    en_div = 1;
    send(8'hFF, 4'd0);
    send(8'hFF, 4'd12);
    send(8'hFD, 4'd3);
    load_valid = 1'b0;
    wait_idle();

    send(8'h0B, 4'd4);
    load_valid = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();
    send(8'h0B, 4'd4);
    load_valid = 1'b0;
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      en_div = $urandom_range(0, 3);
      send(8'($urandom), 4'($urandom_range(0, 12)));
      if ($urandom_range(0, 2) == 0) begin
        load_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    load_valid = 1'b0;
    en_div     = 1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the 1101 sequence-detector stage. Accepts parallel words over a valid/ready handshake and shifts them out one bit per enabled clock on ser_out, which drives the detector's serial `in` input.
- Supports a variable frame length and gapless back-to-back words, so overlapped patterns that span word boundaries still reach the detector intact.
- Sits between the test/host word source and the detector on the same clk/rst domain.

Parameters:
- WIDTH, 8, maximum bits per word; must be >= 2.
- MSB_FIRST, 1, 1 = shift from bit [len-1] down to bit 0; 0 = shift from bit 0 up to bit [len-1].
- LW, $clog2(WIDTH+1), width of load_len. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  a word is offered on load_data/load_len.
- load_ready  output  1  serializer accepts a word on this edge.
- load_data  input  WIDTH  word to serialize. Only the low len bits are used.
- load_len  input  LW  number of bits to send. 0 or >WIDTH is treated as WIDTH.
- en  input  1  bit-advance strobe. Tie to 1 when ser_out drives the detector directly.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a frame bit.
- busy  output  1  frame in progress. Equal to ser_valid.
- done  output  1  one-cycle pulse after the last bit of a frame, when no follow-on word is accepted.

Behaviour:
- Reset, asynchronous, overrides everything, including mid-frame:
  - state=IDLE, shift register=0, bit counter=0.
  - ser_out=0, ser_valid=0, busy=0, done=0.
  - load_ready=1 once rst is low.
- States:
  - IDLE: no frame. ser_out=0, ser_valid=0.
  - SHIFT: frame active. ser_valid=1.
- load_ready is combinational:
  - 1 in IDLE.
  - In SHIFT, 1 only when cnt==1 && en. This is the last-bit hand-off and allows gapless streaming.
  - 0 otherwise.
- Accept = load_valid && load_ready at a rising edge.
  - Effective length is L = (load_len==0 || load_len>WIDTH) ? WIDTH : load_len.
  - The data is latched and cnt=L.
  - On the following cycle, ser_out = first bit and ser_valid=1. Latency is one clock from the accept edge.
- First bit and bit order:
  - MSB_FIRST=1: the first bit is load_data[L-1], then descending.
  - MSB_FIRST=0: the first bit is load_data[0], then ascending.
- In SHIFT:
  - ser_out holds its value until an edge with en=1.
  - At that edge the next bit is presented and cnt decrements.
  - Edges with en=0 change nothing.
- Last-bit edge (cnt==1 && en):
  - With an accept at the same edge, the next word's first bit appears with no gap. ser_valid stays 1 and done stays 0.
  - Without an accept, the next state is IDLE, ser_valid=0, ser_out=0, and done=1 for exactly one cycle.
- load_valid while SHIFT and not at the last bit: ignored, and load_data/load_len are not sampled. The source must hold its word.
- en while IDLE: ignored.
- Each bit is presented for exactly one en-qualified interval. With en=1 a frame of L bits occupies L consecutive clocks.
- Unused high bits of load_data (positions >= L) never appear on ser_out.

Decomposition:
- Shared package seq_pkg holds:
  - state enum {IDLE, SHIFT};
  - the effective-length clamp function;
  - the localparam for LW.
- No sub-module is needed. The block is a single FSM plus a shift register and a down-counter.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> ser_out=0, ser_valid=0, done=0, load_ready=1 immediately after deassert, with no clock edge required.
- MSB-first single frame: WIDTH=8, en=1, load_data=8'h0D, load_len=4 -> ser_out=1,1,0,1 on 4 consecutive cycles, ser_valid high 4 cycles, done pulses on cycle 5. The downstream detector output rises once.
- Back-to-back overlap: load_valid held with 4'hD/len4 then 4'hB/len4 -> ser_out stream 1,1,0,1,1,0,1,1 over 8 consecutive cycles, ser_valid never drops, single done after bit 8. The detector fires twice, once on the pattern that spans the word boundary.
- en pacing: en high every 3rd clock, load 8'hA5 len8 -> each bit held 3 clocks, order 1,0,1,0,0,1,0,1. A load_valid pulsed mid-frame is not accepted.
- Length clamp: load_len=0 and load_len=12 with load_data=8'hFF -> 8 bits of 1 each. load_len=3 with 8'hFD -> bits 1,0,1 only.
- LSB-first plus reset mid-frame: MSB_FIRST=0, load 8'h0B len4 -> 1,1,0,1. Repeat and assert rst after bit 2 -> outputs 0 at once, no done, next frame starts cleanly.
